// File: rtl/evo_pmux_csr_master.sv
// Avalon-MM initiator for the pmux CSR bank: writes the WRADR pointer (cached), then
// performs the DIR/OUT/EN/IN data access, with a bounded wait on every bus phase.
module evo_pmux_csr_master #(
   parameter int CSR_AWIDTH     = 4,
   parameter int CSR_DWIDTH     = 32,
   parameter int IDX_WIDTH      = 4,
   parameter int WRADR_ADDR     = 2,
   parameter int DIR_ADDR       = 3,
   parameter int OUT_ADDR       = 4,
   parameter int EN_ADDR        = 5,
   parameter int IN_ADDR        = 6,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [1:0]            req_sel,
   input  logic [IDX_WIDTH-1:0]  req_index,
   input  logic [CSR_DWIDTH-1:0] req_wdata,
   input  logic                  cache_inv,
   output logic                  rsp_valid,
   output logic [CSR_DWIDTH-1:0] rsp_rdata,
   output logic                  rsp_error,
   output logic [CSR_AWIDTH-1:0] avm_address,
   output logic                  avm_read,
   output logic                  avm_write,
   output logic [CSR_DWIDTH-1:0] avm_writedata,
   input  logic                  avm_waitrequest,
   input  logic                  avm_readdatavalid,
   input  logic [CSR_DWIDTH-1:0] avm_readdata
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_PTR     = 3'd1;
   localparam logic [2:0] S_ACC_WR  = 3'd2;
   localparam logic [2:0] S_ACC_RD  = 3'd3;
   localparam logic [2:0] S_WAIT_RD = 3'd4;
   localparam logic [2:0] S_RSP     = 3'd5;

   localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   logic [2:0]            state;
   logic [TMR_W-1:0]      timer;
   logic                  ptr_valid;
   logic [IDX_WIDTH-1:0]  ptr_cache;
   logic                  cur_write;
   logic [1:0]            cur_sel;
   logic [IDX_WIDTH-1:0]  cur_index;
   logic [CSR_DWIDTH-1:0] cur_wdata;
   logic                  need_ptr;
   logic                  bus_wait;
   logic                  progress;

   function automatic logic [CSR_AWIDTH-1:0] sel_addr(input logic [1:0] sel);
      case (sel)
         2'd0:    return CSR_AWIDTH'(DIR_ADDR);
         2'd1:    return CSR_AWIDTH'(OUT_ADDR);
         2'd2:    return CSR_AWIDTH'(EN_ADDR);
         default: return CSR_AWIDTH'(IN_ADDR);
      endcase
   endfunction

   // IN is not indexed, so it never needs the pointer.
   assign need_ptr = (req_sel != 2'd3) && (!ptr_valid || (ptr_cache != req_index));

   always_comb begin
      bus_wait = 1'b0;
      progress = 1'b0;
      case (state)
         S_PTR, S_ACC_WR, S_ACC_RD: begin
            bus_wait = 1'b1;
            progress = !avm_waitrequest;
         end
         S_WAIT_RD: begin
            bus_wait = 1'b1;
            progress = avm_readdatavalid;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state         <= S_IDLE;
         timer         <= '0;
         ptr_valid     <= 1'b0;
         ptr_cache     <= '0;
         cur_write     <= 1'b0;
         cur_sel       <= '0;
         cur_index     <= '0;
         cur_wdata     <= '0;
         req_ready     <= 1'b1;
         rsp_valid     <= 1'b0;
         rsp_rdata     <= '0;
         rsp_error     <= 1'b0;
         avm_address   <= '0;
         avm_read      <= 1'b0;
         avm_write     <= 1'b0;
         avm_writedata <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  cur_write <= req_write;
                  cur_sel   <= req_sel;
                  cur_index <= req_index;
                  cur_wdata <= req_wdata;
                  req_ready <= 1'b0;
                  timer     <= '0;
                  if (need_ptr) begin
                     state         <= S_PTR;
                     avm_write     <= 1'b1;
                     avm_address   <= CSR_AWIDTH'(WRADR_ADDR);
                     avm_writedata <= CSR_DWIDTH'(req_index);
                  end else begin
                     avm_address <= sel_addr(req_sel);
                     if (req_write) begin
                        state         <= S_ACC_WR;
                        avm_write     <= 1'b1;
                        avm_writedata <= req_wdata;
                     end else begin
                        state    <= S_ACC_RD;
                        avm_read <= 1'b1;
                     end
                  end
               end
            end
            S_PTR: begin
               if (!avm_waitrequest) begin
                  ptr_cache   <= cur_index;
                  ptr_valid   <= 1'b1;
                  timer       <= '0;
                  avm_address <= sel_addr(cur_sel);
                  if (cur_write) begin
                     state         <= S_ACC_WR;
                     avm_writedata <= cur_wdata;
                  end else begin
                     state     <= S_ACC_RD;
                     avm_write <= 1'b0;
                     avm_read  <= 1'b1;
                  end
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            S_ACC_WR: begin
               if (!avm_waitrequest) begin
                  state     <= S_RSP;
                  timer     <= '0;
                  avm_write <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_error <= 1'b0;
                  rsp_rdata <= '0;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            S_ACC_RD: begin
               if (!avm_waitrequest) begin
                  state    <= S_WAIT_RD;
                  timer    <= '0;
                  avm_read <= 1'b0;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            S_WAIT_RD: begin
               if (avm_readdatavalid) begin
                  state     <= S_RSP;
                  timer     <= '0;
                  rsp_valid <= 1'b1;
                  rsp_error <= 1'b0;
                  rsp_rdata <= avm_readdata;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            S_RSP: begin
               state     <= S_IDLE;
               rsp_valid <= 1'b0;
               rsp_error <= 1'b0;
               rsp_rdata <= '0;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= S_IDLE;
               req_ready <= 1'b1;
            end
         endcase

         // Abort the whole request; the pointer state on the target is now unknown.
         if (bus_wait && !progress && (timer == TMR_LAST)) begin
            state     <= S_RSP;
            timer     <= '0;
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
            ptr_valid <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_error <= 1'b1;
            rsp_rdata <= '0;
         end

         if (cache_inv) begin
            ptr_valid <= 1'b0;
         end
      end
   end

endmodule
